// File: rtl/md_pkg.sv
// Shared MD types and constants: position tuples, cell tag, filter defaults
// and the distributor FSM state encoding.
package md_pkg;

  localparam int NUM_FILTER         = 7;
  localparam int NUM_NEIGHBOR_CELLS = 13;
  localparam int OFFSET_WIDTH       = 13;
  localparam int CELL_ID_WIDTH      = 3;
  localparam int DATA_WIDTH         = CELL_ID_WIDTH + OFFSET_WIDTH;

  localparam logic [CELL_ID_WIDTH-1:0] CELL_2 = 3'd2;

  typedef struct packed {
    logic [OFFSET_WIDTH-1:0] z;
    logic [OFFSET_WIDTH-1:0] y;
    logic [OFFSET_WIDTH-1:0] x;
  } offset_tuple_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] z;
    logic [DATA_WIDTH-1:0] y;
    logic [DATA_WIDTH-1:0] x;
  } data_tuple_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } dist_state_t;

  // Home-cell particles are always tagged as cell 2 on every axis.
  function automatic data_tuple_t assemble_position(input offset_tuple_t o);
    data_tuple_t d;
    d.z = {CELL_2, o.z};
    d.y = {CELL_2, o.y};
    d.x = {CELL_2, o.x};
    return d;
  endfunction

endpackage

// File: rtl/pos_dist_hold_reg.sv
// One-entry skid register: parks a returning memory word while the filters
// pause, and replays it ahead of any newer data.
module pos_dist_hold_reg
  import md_pkg::*;
#(
  parameter int PHASE_W = 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  offset_tuple_t      in_data,
  input  logic [PHASE_W-1:0] in_phase,
  input  logic               pause,
  output logic               out_valid,
  output offset_tuple_t      out_data,
  output logic [PHASE_W-1:0] out_phase,
  output logic               hold_valid
);

  offset_tuple_t      hold_data;
  logic [PHASE_W-1:0] hold_phase;

  // The read side never issues while the entry is full, so a capture and a
  // pending replay cannot coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_phase <= '0;
    end else if (in_valid && pause) begin
      hold_valid <= 1'b1;
      hold_data  <= in_data;
      hold_phase <= in_phase;
    end else if (!pause) begin
      hold_valid <= 1'b0;
    end
  end

  assign out_valid = ~pause & (hold_valid | in_valid);
  assign out_data  = hold_valid ? hold_data  : in_data;
  assign out_phase = hold_valid ? hold_phase : in_phase;

endmodule

// File: rtl/pos_data_distributor_pipelined.sv
// Streams home-cell positions to the filters once per phase.
// Define POS_DIST_STALL_CNT_EN to add the saturating stall_cnt output.
module pos_data_distributor_pipelined
  import md_pkg::*;
#(
  parameter  int NUM_FILTER = md_pkg::NUM_FILTER,
  parameter  int NUM_PHASES = 2,
  parameter  int PID_W      = 8,
  localparam int PHASE_W    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
)(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [PID_W:0]                   home_count,
  output logic                             rd_en,
  output logic [PID_W-1:0]                 rd_addr,
  input  offset_tuple_t                    rd_nb_position,
  input  logic                             pause_reading,
  input  logic [NUM_PHASES*NUM_FILTER-1:0] broadcast_done,
  input  logic                             ref_particle_read,
  input  logic [NUM_FILTER-1:0]            ref_valid,
  output logic [NUM_FILTER-1:0]            pair_valid,
  output data_tuple_t                      assembled_position,
  output logic [PHASE_W-1:0]               phase,
  output logic                             busy,
  output logic                             done
`ifdef POS_DIST_STALL_CNT_EN
  ,
  output logic [31:0]                      stall_cnt
`endif
);

  dist_state_t        state, state_next;
  logic [PID_W:0]     count_r;
  logic               rd_pending;
  logic [PHASE_W-1:0] rd_phase;
  logic               hold_valid;
  logic               emit;
  offset_tuple_t      emit_data;
  logic [PHASE_W-1:0] emit_phase;
  logic               last_addr;
  logic               last_phase;
  logic               drain_clear;
  logic [NUM_FILTER-1:0] done_slice;
  logic [NUM_FILTER-1:0] pv_next;

  assign last_addr   = ({1'b0, rd_addr} == (count_r - 1'b1));
  assign last_phase  = (phase == PHASE_W'(NUM_PHASES - 1));
  assign drain_clear = ~rd_pending & ~hold_valid;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (home_count == '0) ? DONE : READ;
      end
      READ: begin
        rd_en = ~pause_reading & ~hold_valid;
        if (rd_en && last_addr) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_clear) state_next = last_phase ? DONE : READ;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_addr <= '0;
      phase   <= '0;
      count_r <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            count_r <= home_count;
            rd_addr <= '0;
            phase   <= '0;
          end
        end
        READ: begin
          if (rd_en) rd_addr <= rd_addr + 1'b1;
        end
        DRAIN: begin
          if (drain_clear) begin
            rd_addr <= '0;
            if (!last_phase) phase <= phase + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Each read carries its phase so the mask follows the particle, not the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending <= 1'b0;
      rd_phase   <= '0;
    end else begin
      rd_pending <= rd_en;
      rd_phase   <= phase;
    end
  end

  pos_dist_hold_reg #(
    .PHASE_W (PHASE_W)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (rd_pending),
    .in_data    (rd_nb_position),
    .in_phase   (rd_phase),
    .pause      (pause_reading),
    .out_valid  (emit),
    .out_data   (emit_data),
    .out_phase  (emit_phase),
    .hold_valid (hold_valid)
  );

  always_comb begin
    done_slice = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (emit_phase == PHASE_W'(p)) done_slice = broadcast_done[p*NUM_FILTER +: NUM_FILTER];
    end
    pv_next = {NUM_FILTER{emit}} & ~done_slice & ref_valid;
    if (emit_phase == '0) pv_next[0] = pv_next[0] & ref_particle_read;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_valid         <= '0;
      assembled_position <= '0;
    end else begin
      pair_valid <= pv_next;
      if (emit) assembled_position <= assemble_position(emit_data);
    end
  end

`ifdef POS_DIST_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (busy && pause_reading && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pos_data_distributor_pipelined.md
POS_DATA_DISTRIBUTOR_PIPELINED -- requirements
Module: pos_data_distributor_pipelined

Interface
REQ-001 SHALL have parameter NUM_FILTER, default 7: filters fed per phase.
REQ-002 SHALL have parameter NUM_PHASES, default 2: home-cell passes per cell pair set.
REQ-003 SHALL have parameter PID_W, default 8: home-cell particle address width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins iteration when idle.
REQ-007 home_count  in  PID_W+1  number of home-cell particles, sampled on start.
REQ-008 rd_en  out  1  home-cell position memory read strobe.
REQ-009 rd_addr  out  PID_W  home-cell read address.
REQ-010 rd_nb_position  in  offset_tuple_t  memory data, valid exactly 1 cycle after rd_en.
REQ-011 pause_reading  in  1  back pressure from filters.
REQ-012 broadcast_done  in  NUM_PHASES*NUM_FILTER  per-phase, per-filter neighbor-exhausted flags.
REQ-013 ref_particle_read  in  1  reference particle already read (self-pair mask).
REQ-014 ref_valid  in  NUM_FILTER  per-filter reference valid.
REQ-015 pair_valid  out  NUM_FILTER  per-filter pair valid, registered.
REQ-016 assembled_position  out  data_tuple_t  {CELL_2,z,CELL_2,y,CELL_2,x} of emitted particle, registered.
REQ-017 phase  out  $clog2(NUM_PHASES) (min 1)  current phase.
REQ-018 busy / done  out  1 each  busy while not IDLE; done one-cycle pulse at end.

Function
REQ-019 FSM states IDLE, READ, DRAIN, DONE; start ignored outside IDLE.
REQ-020 IDLE+start: home_count=0 -> DONE; else phase=0, rd_addr=0 -> READ.
REQ-021 READ: rd_en = ~pause_reading & ~hold_valid; rd_addr increments after each issued read.
REQ-022 Last address (home_count-1) issued -> DRAIN; DRAIN waits until no read in flight and hold empty.
REQ-023 DRAIN exit: phase<NUM_PHASES-1 -> phase+1, rd_addr=0, READ; else DONE.
REQ-024 DONE: done=1 one cycle, -> IDLE.
REQ-025 Latency: rd_en at cycle t -> pair_valid/assembled_position at t+2 when not paused.
REQ-026 Returning data while pause_reading=1 SHALL be captured in a 1-entry hold register; never dropped, never duplicated.
REQ-027 Hold entry emitted on first cycle pause_reading=0, before any new data; no new read issued while hold full.
REQ-028 pair_valid[f] = emit & ~broadcast_done[phase*NUM_FILTER+f] & ref_valid[f]; phase 0 filter 0 additionally & ref_particle_read.
REQ-029 pair_valid SHALL be all-zero on any cycle with no emission or pause_reading=1.
REQ-030 Phase used in REQ-028 is the phase of the emitted particle, not current FSM phase.

Reset
REQ-031 rst: state=IDLE, rd_en=0, rd_addr=0, phase=0, pair_valid=0, assembled_position=0, hold empty, busy=0, done=0.
REQ-032 rst mid-operation aborts immediately; in-flight read data discarded; no done pulse.

Configuration
REQ-033 Macro POS_DIST_STALL_CNT_EN defined: adds output stall_cnt (32 bits), counts cycles busy & pause_reading, saturates, cleared by rst and start.
REQ-034 Macro undefined: no stall_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-035 offset_tuple_t, data_tuple_t, CELL_2, NUM_FILTER/NUM_NEIGHBOR_CELLS defaults and FSM state enum SHALL live in md_pkg.
REQ-036 One sub-module, pos_dist_hold_reg (1-entry hold/skid register), natural; FSM and address counter in top.

Verification
REQ-037 home_count=5, NUM_PHASES=2, no pause, all ref_valid=1, broadcast_done=0 -> addrs 0..4 twice, 10 emissions, done at cycle 2*5+drain, pair_valid=7'h7F except phase 0 bit0 follows ref_particle_read.
REQ-038 pause_reading high cycles 3-6 with read at 2 -> data held, emitted cycle 7, no loss, addr sequence unbroken.
REQ-039 home_count=0, start -> done one cycle later, rd_en never asserted.
REQ-040 broadcast_done=14'h0080, phase 1 -> pair_valid bit0=0, others=1; phase 0 unaffected.
REQ-041 rst asserted mid-READ of phase 1 -> all outputs zero next cycle, no done, new start restarts at addr 0, phase 0.
REQ-042 With POS_DIST_STALL_CNT_EN, 4 paused busy cycles -> stall_cnt=4; next start clears to 0.
